// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: sizes, aligns and sequences one data-memory access per
// instruction through IDLE -> REQ -> DONE. Optional bus timeout guarded by LSU_TIMEOUT_EN.
module mem_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;

  logic        is_load, is_store, access, illegal, start;
  logic [1:0]  ofs;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] fmt;

  assign ofs      = ALUResultM[1:0];
  assign is_load  = MemReadM;
  assign is_store = MemWriteM & ~MemReadM;
  assign access   = MemReadM | MemWriteM;

  always_comb begin
    illegal = 1'b0;
    case (Funct3M)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = ofs[0];
      3'b010:         illegal = |ofs;
      default:        illegal = 1'b1;
    endcase
    // stores have no unsigned variants
    if (is_store && Funct3M[2]) illegal = 1'b1;
  end

  assign start     = (state == IDLE) & access & ~illegal;
  assign StallM    = start | (state == REQ);
  assign MisalignM = (state == IDLE) & access & illegal;
  assign dmem_req  = (state == REQ);
  assign dmem_we   = (state == REQ) & is_store;
  assign dmem_addr = {ALUResultM[31:2], 2'b00};

  always_comb begin
    dmem_wstrb = 4'b0000;
    dmem_wdata = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        dmem_wstrb = 4'b0001 << ofs;
        dmem_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        dmem_wstrb = 4'b0011 << {ofs[1], 1'b0};
        dmem_wdata = {2{WriteDataM[15:0]}};
      end
      2'b10:   dmem_wstrb = 4'b1111;
      default: dmem_wstrb = 4'b0000;
    endcase
    if (!is_store) dmem_wstrb = 4'b0000;
  end

  always_comb begin
    case (ofs)
      2'd0:    rbyte = dmem_rdata[7:0];
      2'd1:    rbyte = dmem_rdata[15:8];
      2'd2:    rbyte = dmem_rdata[23:16];
      default: rbyte = dmem_rdata[31:24];
    endcase
    rhalf = ofs[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (Funct3M)
      3'b000:  fmt = {{24{rbyte[7]}}, rbyte};
      3'b001:  fmt = {{16{rhalf[15]}}, rhalf};
      3'b100:  fmt = {24'h0, rbyte};
      3'b101:  fmt = {16'h0, rhalf};
      default: fmt = dmem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt;
  logic       bus_err;
  assign BusErrM = bus_err;
`else
  assign BusErrM = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ReadDataM <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      cnt       <= 8'h0;
      bus_err   <= 1'b0;
`endif
    end else begin
`ifdef LSU_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state)
        IDLE: if (start) begin
          state <= REQ;
`ifdef LSU_TIMEOUT_EN
          cnt   <= 8'h0;
`endif
        end
        REQ: begin
          if (dmem_ack) begin
            state <= DONE;
            if (is_load) ReadDataM <= fmt;
          end
`ifdef LSU_TIMEOUT_EN
          // the 255th unacknowledged REQ cycle gives up on the bus
          else if (cnt == 8'd254) begin
            state   <= DONE;
            cnt     <= 8'd255;
            bus_err <= 1'b1;
            if (is_load) ReadDataM <= 32'h0;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: reset, load formatting, store lanes, misalignment,
// back-to-back accesses, reset abort and (with LSU_TIMEOUT_EN) bus timeout.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b0;
  logic [31:0] ALUResultM = 32'h0, WriteDataM = 32'h0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'h0, ReadDataM;
  logic [3:0]  dmem_wstrb;
  logic        StallM, MisalignM, BusErrM;

  int n_chk = 0, n_fail = 0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_strb;
  logic        s_we, s_mis;

  mem_lsu dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .ReadDataM(ReadDataM), .StallM(StallM),
    .MisalignM(MisalignM), .BusErrM(BusErrM)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3;
    ALUResultM = addr; WriteDataM = wd; dmem_rdata = rdat;
  endtask

  // Steps the clock while StallM is high; acks on the ack_after-th REQ cycle (0 = never).
  task automatic run(input int ack_after, output int stall_n, output int req_n);
    stall_n = 0; req_n = 0; s_mis = 1'b0;
    forever begin
      #1;
      if (!StallM || stall_n > 400) break;
      stall_n++;
      if (dmem_req) begin
        req_n++;
        if (req_n == 1) begin
          s_addr = dmem_addr; s_wdata = dmem_wdata; s_strb = dmem_wstrb; s_we = dmem_we;
        end
        if (MisalignM) s_mis = 1'b1;
        if (ack_after != 0 && req_n >= ack_after) dmem_ack = 1'b1;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
  endtask

  task automatic finish_access();
    MemReadM = 1'b0; MemWriteM = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #2;
    n_chk++; if ({StallM, dmem_req, dmem_we, MisalignM} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000", {StallM, dmem_req, dmem_we, MisalignM}); end
    n_chk++; if (dmem_wstrb !== 4'b0000) begin n_fail++;
      $display("FAIL reset_wstrb: got %b want 0000", dmem_wstrb); end
    n_chk++; if (ReadDataM !== 32'h0 || BusErrM !== 1'b0) begin n_fail++;
      $display("FAIL reset_rdata: got %h/%b want 0/0", ReadDataM, BusErrM); end
  endtask

  task automatic test_lb();
    int st, rq;
    apply(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FFFFFF);
    run(1, st, rq);
    n_chk++; if (st !== 2 || rq !== 1) begin n_fail++;
      $display("FAIL lb_stall: got stall=%0d req=%0d want 2/1", st, rq); end
    n_chk++; if (ReadDataM !== 32'hFFFFFF80) begin n_fail++;
      $display("FAIL lb_data: got %h want ffffff80", ReadDataM); end
    n_chk++; if (dmem_req !== 1'b0 || s_addr !== 32'h1000 || s_we !== 1'b0 || s_strb !== 4'b0000) begin n_fail++;
      $display("FAIL lb_bus: req=%b addr=%h we=%b strb=%b want 0/1000/0/0000", dmem_req, s_addr, s_we, s_strb); end
    finish_access();
  endtask

  task automatic test_sh();
    int st, rq;
    apply(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000BEEF, 32'h0);
    run(3, st, rq);
    n_chk++; if (st !== 4 || rq !== 3) begin n_fail++;
      $display("FAIL sh_stall: got stall=%0d req=%0d want 4/3", st, rq); end
    n_chk++; if (s_strb !== 4'b1100 || s_wdata !== 32'hBEEFBEEF || s_addr !== 32'h2000 || s_we !== 1'b1) begin n_fail++;
      $display("FAIL sh_bus: strb=%b wdata=%h addr=%h we=%b want 1100/beefbeef/2000/1", s_strb, s_wdata, s_addr, s_we); end
    n_chk++; if (ReadDataM !== 32'hFFFFFF80 || s_mis !== 1'b0) begin n_fail++;
      $display("FAIL sh_keep: rdata=%h mis=%b want ffffff80/0", ReadDataM, s_mis); end
    finish_access();
    apply(1'b0, 1'b1, 3'b000, 32'h0201, 32'h12345678, 32'h0);
    run(1, st, rq);
    n_chk++; if (s_strb !== 4'b0010 || s_wdata !== 32'h78787878) begin n_fail++;
      $display("FAIL sb_bus: strb=%b wdata=%h want 0010/78787878", s_strb, s_wdata); end
    finish_access();
  endtask

  task automatic test_misalign();
    logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b011};
    logic        wr [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ad [3] = '{32'h3001, 32'h0001, 32'h0000};
    for (int i = 0; i < 3; i++) begin
      apply(~wr[i], wr[i], f3[i], ad[i], 32'h0, 32'h0);
      #1;
      n_chk++; if ({MisalignM, StallM, dmem_req} !== 3'b100) begin n_fail++;
        $display("FAIL misalign_%0d: mis/stall/req=%b want 100", i, {MisalignM, StallM, dmem_req}); end
      @(posedge clk); #1;
      n_chk++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin n_fail++;
        $display("FAIL misalign_noreq_%0d: req=%b stall=%b want 0/0", i, dmem_req, StallM); end
      finish_access();
    end
  endtask

  task automatic test_ack_idle();
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    repeat (2) @(posedge clk);
    #1 dmem_ack = 1'b0;
    n_chk++; if (ReadDataM !== 32'hFFFFFF80 || dmem_req !== 1'b0) begin n_fail++;
      $display("FAIL ack_idle: rdata=%h req=%b want ffffff80/0", ReadDataM, dmem_req); end
  endtask

  task automatic test_load_fmt();
    int st, rq;
    logic [2:0]  f3 [5] = '{3'b001, 3'b101, 3'b100, 3'b000, 3'b010};
    logic [31:0] ad [5] = '{32'h102, 32'h102, 32'h101, 32'h100, 32'h100};
    logic [31:0] rd [5] = '{32'h80017FFF, 32'h80017FFF, 32'h0000A500, 32'h0000007F, 32'hDEADBEEF};
    logic [31:0] ex [5] = '{32'hFFFF8001, 32'h00008001, 32'h000000A5, 32'h0000007F, 32'hDEADBEEF};
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, f3[i], ad[i], 32'h0, rd[i]);
      run(1, st, rq);
      n_chk++; if (ReadDataM !== ex[i] || st !== 2) begin n_fail++;
        $display("FAIL load_fmt_%0d: got %h stall=%0d want %h/2", i, ReadDataM, st, ex[i]); end
      finish_access();
    end
  endtask

  task automatic test_back_to_back();
    int st1, rq1, st2, rq2;
    apply(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h12345678);
    run(1, st1, rq1);
    apply(1'b0, 1'b1, 3'b010, 32'h14, 32'hCAFEF00D, 32'h0);
    @(posedge clk); #1;
    n_chk++; if (dmem_req !== 1'b0 || StallM !== 1'b1) begin n_fail++;
      $display("FAIL b2b_idle: req=%b stall=%b want 0/1", dmem_req, StallM); end
    run(1, st2, rq2);
    n_chk++; if (rq1 + rq2 !== 2 || st1 !== 2 || st2 !== 2) begin n_fail++;
      $display("FAIL b2b_count: req=%0d stall=%0d,%0d want 2/2,2", rq1 + rq2, st1, st2); end
    n_chk++; if (ReadDataM !== 32'h12345678 || s_strb !== 4'b1111 || s_addr !== 32'h14 || s_wdata !== 32'hCAFEF00D) begin n_fail++;
      $display("FAIL b2b_data: rdata=%h strb=%b addr=%h wdata=%h want 12345678/1111/14/cafef00d",
               ReadDataM, s_strb, s_addr, s_wdata); end
    finish_access();
    n_chk++; if (dmem_req !== 1'b0 || BusErrM !== 1'b0) begin n_fail++;
      $display("FAIL b2b_end: req=%b buserr=%b want 0/0", dmem_req, BusErrM); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int st, rq;
    apply(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0);
    run(0, st, rq);
    n_chk++; if (rq !== 255 || st !== 256) begin n_fail++;
      $display("FAIL timeout_len: req=%0d stall=%0d want 255/256", rq, st); end
    n_chk++; if (BusErrM !== 1'b1 || ReadDataM !== 32'h0 || StallM !== 1'b0) begin n_fail++;
      $display("FAIL timeout_done: buserr=%b rdata=%h stall=%b want 1/0/0", BusErrM, ReadDataM, StallM); end
    finish_access();
    n_chk++; if (BusErrM !== 1'b0) begin n_fail++;
      $display("FAIL timeout_pulse: buserr=%b want 0", BusErrM); end
  endtask
`endif

  task automatic test_reset_in_req();
    int st, rq;
    apply(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h55AA55AA);
    run(1, st, rq);
    finish_access();
    n_chk++; if (ReadDataM !== 32'h55AA55AA) begin n_fail++;
      $display("FAIL rst_pre: got %h want 55aa55aa", ReadDataM); end
    apply(1'b1, 1'b0, 3'b101, 32'h4002, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++; if (dmem_req !== 1'b1) begin n_fail++;
      $display("FAIL rst_req2: req=%b want 1", dmem_req); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (dmem_req !== 1'b0 || ReadDataM !== 32'h0) begin n_fail++;
      $display("FAIL rst_abort: req=%b rdata=%h want 0/0", dmem_req, ReadDataM); end
    MemReadM = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_misalign();
    test_ack_idle();
    test_load_fmt();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-low.
- MemReadM  in  1  load in MEM stage.
- MemWriteM  in  1  store in MEM stage.
- Funct3M  in  3  access size/sign.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, LSB-justified.
- dmem_req  out  1  bus request.
- dmem_we  out  1  bus write.
- dmem_addr  out  32  word address, {ALUResultM[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte enables.
- dmem_ack  in  1  bus completion, qualifies dmem_rdata.
- dmem_rdata  in  32  bus read word.
- ReadDataM  out  32  formatted load result to MEM/WB.
- StallM  out  1  freeze IF..MEM.
- MisalignM  out  1  misaligned or illegal access flag.
- BusErrM  out  1  bus timeout pulse.

Function
REQ-002 An access SHALL be MemReadM|MemWriteM; if both are set it SHALL be a load.
REQ-003 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-004 IDLE: a legal access SHALL move to REQ next edge; StallM=1 combinationally in that cycle.
REQ-005 REQ: dmem_req=1 and StallM=1; address/data/strobes SHALL be stable.
REQ-006 REQ: dmem_ack=1 SHALL move to DONE next edge, and a load SHALL capture formatted dmem_rdata into ReadDataM on that edge.
REQ-007 DONE: StallM=0 and dmem_req=0; the FSM SHALL return to IDLE next edge.
REQ-008 Minimum MEM-stage occupancy SHALL be 3 cycles (ack in first REQ cycle); each extra REQ cycle SHALL add one.
REQ-009 ReadDataM SHALL hold its last value until the next load capture; stores SHALL NOT modify it.
REQ-010 Loads SHALL be formatted by Funct3M:
- 000 LB: sign-extended byte at addr[1:0].
- 001 LH: sign-extended half at addr[1].
- 010 LW: full word.
- 100 LBU: zero-extended byte.
- 101 LHU: zero-extended half.
REQ-011 Stores SHALL drive dmem_wstrb and dmem_wdata by Funct3M:
- SB: strb=0001<<addr[1:0], wdata={4{byte}}.
- SH: strb=0011<<{addr[1],1'b0}, wdata={2{half}}.
- SW: strb=1111.
- Loads: strb=0000.
REQ-012 Misaligned accesses (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) and undefined Funct3M SHALL set MisalignM=1 combinationally in IDLE, issue no request, and not stall.
REQ-013 dmem_ack outside REQ SHALL be ignored.
REQ-014 MisalignM SHALL be 0 outside IDLE.

Reset
REQ-015 reset=0 at a rising edge SHALL force IDLE, ReadDataM=0 and BusErrM=0, and SHALL clear the timeout counter; an in-flight REQ SHALL be abandoned and dmem_req SHALL be 0 from the following cycle.
REQ-016 After reset, with no access present, StallM, dmem_req, dmem_we, dmem_wstrb and MisalignM SHALL all be 0.

Configuration
REQ-017 With LSU_TIMEOUT_EN defined, an 8-bit counter SHALL clear on REQ entry and increment each REQ cycle without ack; on reaching 255 the FSM SHALL move to DONE, pulse BusErrM for one cycle, and a load SHALL write ReadDataM=0.
REQ-018 Without LSU_TIMEOUT_EN, REQ SHALL wait indefinitely for dmem_ack, BusErrM SHALL be constant 0, and no counter SHALL exist.

Verification
REQ-019 LB at addr 0x1003, ack in first REQ cycle, rdata=0x80FFFFFF -> ReadDataM=0xFFFFFF80, StallM high exactly 2 cycles.
REQ-020 SH at addr 0x2002, WriteDataM=0x0000BEEF, ack after 3 REQ cycles -> dmem_wstrb=1100, dmem_wdata=0xBEEFBEEF, dmem_addr=0x2000, StallM high 4 cycles.
REQ-021 LW at addr 0x3001 -> MisalignM=1, dmem_req stays 0, StallM=0.
REQ-022 LHU at 0x4002 with reset low during second REQ cycle -> next cycle IDLE, dmem_req=0, ReadDataM=0.
REQ-023 LSU_TIMEOUT_EN, LW with no ack -> BusErrM one-cycle pulse after 255 REQ cycles, ReadDataM=0, StallM released in DONE.
REQ-024 Back-to-back LW 0x10 then SW 0x14, both acked immediately -> second access enters REQ the cycle after DONE, no lost or duplicated dmem_req.
